alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_mul_iter.sv | 60 ++++++
 rtl/alu_pipe.sv | 150 +++++++++++++++
 tb/tb_alu_pipe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, control states and condition-code flags.
package alu_pkg;

  typedef enum logic [3:0] {
    OpNop  = 4'd0,
    OpAdd  = 4'd1,
    OpSub  = 4'd2,
    OpAnd  = 4'd3,
    OpOr   = 4'd4,
    OpNot  = 4'd5,
    OpInc  = 4'd6,
    OpDec  = 4'd7,
    OpShl  = 4'd8,
    OpShr  = 4'd9,
    OpSetc = 4'd10,
    OpClrc = 4'd11,
    OpMul  = 4'd12
  } op_e;

  typedef enum logic [0:0] {
    StIdle,
    StMulBusy
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
  } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier; one multiplier bit per cycle, N cycles total.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic           abort_i,
  input  logic [N-1:0]   mcand_i,
  input  logic [N-1:0]   mplier_i,
  output logic           done_o,
  output logic [2*N-1:0] prod_o
);

  localparam int unsigned CntW = $clog2(N + 1);

  logic [2*N-1:0] acc_q;
  logic [N-1:0]   mcand_q;
  logic [CntW-1:0] cnt_q;
  logic           busy_q;

  // acc holds {partial high, remaining multiplier bits}; each step adds and shifts right.
  function automatic logic [2*N-1:0] step(input logic [2*N-1:0] acc, input logic [N-1:0] mc);
    logic [N:0] hi;
    hi = {1'b0, acc[2*N-1:N]} + ({(N+1){acc[0]}} & {1'b0, mc});
    return {hi, acc[N-1:1]};
  endfunction

  // The start edge already performs the first step, so done marks the Nth step in flight.
  assign done_o = busy_q && (cnt_q == CntW'(N - 1));
  assign prod_o = step(acc_q, mcand_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (abort_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      acc_q   <= step({{N{1'b0}}, mplier_i}, mcand_i);
      mcand_q <= mcand_i;
      cnt_q   <= CntW'(1);
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      acc_q <= step(acc_q, mcand_q);
      if (done_o) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with single-cycle ops and an optional iterative multiply that stalls intake.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [N-1:0] in_src,
  input  logic [N-1:0] in_dst,
  output logic         out_valid,
  output logic [N-1:0] out,
  output logic [N-1:0] out_hi,
  output logic         carryFlag,
  output logic         zeroFlag,
  output logic         negFlag
);

  state_e         state_q;
  logic [N-1:0]   out_q, out_hi_q;
  logic           out_valid_q;
  flags_t         flags_q;

  logic           accept, mul_start, mul_done;
  logic [2*N-1:0] mul_prod;
  logic [N:0]     ext;
  logic [N-1:0]   alu_res;
  logic           alu_carry, alu_wr;

  assign in_ready  = (state_q == StIdle);
  assign accept    = in_valid && in_ready && !flush;
  assign mul_start = accept && (op == OpMul) && MUL_EN;

  always_comb begin
    ext       = '0;
    alu_res   = out_q;
    alu_carry = flags_q.carry;
    alu_wr    = 1'b0;
    case (op)
      OpAdd: begin
        ext = {1'b0, in_dst} + {1'b0, in_src};
        {alu_carry, alu_res} = ext;
        alu_wr = 1'b1;
      end
      // Bit N of the extended difference is the borrow.
      OpSub: begin
        ext = {1'b0, in_dst} - {1'b0, in_src};
        {alu_carry, alu_res} = ext;
        alu_wr = 1'b1;
      end
      OpAnd: begin alu_res = in_dst & in_src; alu_wr = 1'b1; end
      OpOr:  begin alu_res = in_dst | in_src; alu_wr = 1'b1; end
      OpNot: begin alu_res = ~in_dst;         alu_wr = 1'b1; end
      OpInc: begin
        ext = {1'b0, in_dst} + (N+1)'(1);
        {alu_carry, alu_res} = ext;
        alu_wr = 1'b1;
      end
      OpDec: begin
        ext = {1'b0, in_dst} - (N+1)'(1);
        {alu_carry, alu_res} = ext;
        alu_wr = 1'b1;
      end
      OpShl: begin
        alu_res   = {in_dst[N-2:0], 1'b0};
        alu_carry = in_dst[N-1];
        alu_wr    = 1'b1;
      end
      OpShr: begin
        alu_res   = {1'b0, in_dst[N-1:1]};
        alu_carry = in_dst[0];
        alu_wr    = 1'b1;
      end
      OpSetc:  alu_carry = 1'b1;
      OpClrc:  alu_carry = 1'b0;
      default: ;
    endcase
  end

  if (MUL_EN) begin : g_mul
    alu_mul_iter #(.N(N)) u_mul (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .start_i  (mul_start),
      .abort_i  (flush),
      .mcand_i  (in_dst),
      .mplier_i (in_src),
      .done_o   (mul_done),
      .prod_o   (mul_prod)
    );
  end else begin : g_no_mul
    assign mul_done = 1'b0;
    assign mul_prod = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_q       <= '0;
      out_hi_q    <= '0;
      out_valid_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (mul_start) begin
            state_q <= StMulBusy;
          end else if (accept) begin
            out_valid_q   <= 1'b1;
            flags_q.carry <= alu_carry;
            if (alu_wr) begin
              out_q        <= alu_res;
              out_hi_q     <= '0;
              flags_q.zero <= (alu_res == '0);
              flags_q.neg  <= alu_res[N-1];
            end
          end
        end
        StMulBusy: begin
          if (flush) begin
            state_q <= StIdle;
          end else if (mul_done) begin
            state_q       <= StIdle;
            out_valid_q   <= 1'b1;
            out_q         <= mul_prod[N-1:0];
            out_hi_q      <= mul_prod[2*N-1:N];
            flags_q.carry <= |mul_prod[2*N-1:N];
            flags_q.zero  <= (mul_prod == '0);
            flags_q.neg   <= mul_prod[2*N-1];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_hi    = out_hi_q;
  assign carryFlag = flags_q.carry;
  assign zeroFlag  = flags_q.zero;
  assign negFlag   = flags_q.neg;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: arithmetic reference model checked every cycle plus directed literal checks.
module tb_alu_pipe;

  localparam int unsigned N = 16;
  localparam longint Mask = (64'd1 << N) - 1;

  logic         clk, rst_n, flush, in_valid, in_ready, out_valid;
  logic [3:0]   op;
  logic [N-1:0] in_src, in_dst, out, out_hi;
  logic         carryFlag, zeroFlag, negFlag;

  int total = 0;
  int bad   = 0;

  alu_pipe #(.N(N), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_src    (in_src),
    .in_dst    (in_dst),
    .out_valid (out_valid),
    .out       (out),
    .out_hi    (out_hi),
    .carryFlag (carryFlag),
    .zeroFlag  (zeroFlag),
    .negFlag   (negFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state plus cycles left on an outstanding multiply.
  longint m_out, m_hi, m_c, m_z, m_n, m_valid, m_busy, m_prod;

  initial begin
    longint d, s, r;
    m_out = 0; m_hi = 0; m_c = 0; m_z = 0; m_n = 0; m_valid = 0; m_busy = 0; m_prod = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_out = 0; m_hi = 0; m_c = 0; m_z = 0; m_n = 0; m_valid = 0; m_busy = 0;
      end else begin
        m_valid = 0;
        d = longint'(in_dst);
        s = longint'(in_src);
        if (m_busy > 0) begin
          if (flush) m_busy = 0;
          else begin
            m_busy--;
            if (m_busy == 0) begin
              m_out = m_prod & Mask;
              m_hi  = m_prod >> N;
              m_c   = (m_hi != 0) ? 1 : 0;
              m_z   = (m_prod == 0) ? 1 : 0;
              m_n   = (m_hi >> (N - 1)) & 1;
              m_valid = 1;
            end
          end
        end else if (in_valid && !flush) begin
          m_valid = 1;
          r = -1;
          case (op)
            4'd1:  begin r = (d + s) & Mask; m_c = ((d + s) >> N) & 1; end
            4'd2:  begin r = (d - s) & Mask; m_c = (s > d) ? 1 : 0; end
            4'd3:  r = d & s;
            4'd4:  r = d | s;
            4'd5:  r = (~d) & Mask;
            4'd6:  begin r = (d + 1) & Mask; m_c = ((d + 1) >> N) & 1; end
            4'd7:  begin r = (d - 1) & Mask; m_c = (d == 0) ? 1 : 0; end
            4'd8:  begin r = (d * 2) & Mask; m_c = (d >> (N - 1)) & 1; end
            4'd9:  begin r = d / 2; m_c = d % 2; end
            4'd10: m_c = 1;
            4'd11: m_c = 0;
            4'd12: begin m_valid = 0; m_busy = N - 1; m_prod = d * s; end
            default: ;
          endcase
          if (r >= 0) begin
            m_out = r; m_hi = 0;
            m_z = (r == 0) ? 1 : 0;
            m_n = (r >> (N - 1)) & 1;
          end
        end
      end
      #1;
      chk("cyc_out_valid", out_valid, m_valid);
      chk("cyc_out", out, m_out);
      chk("cyc_out_hi", out_hi, m_hi);
      chk("cyc_carry", carryFlag, m_c);
      chk("cyc_zero", zeroFlag, m_z);
      chk("cyc_neg", negFlag, m_n);
      chk("cyc_in_ready", in_ready, (m_busy == 0) ? 1 : 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic issue(input logic [3:0] o, input logic [N-1:0] d, input logic [N-1:0] s);
    @(negedge clk);
    op = o; in_dst = d; in_src = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [3:0]   t_op  [8] = '{4'd9, 4'd7, 4'd5, 4'd4, 4'd13, 4'd11, 4'd1, 4'd2};
  logic [N-1:0] t_dst [8] = '{16'h0003, 16'h0000, 16'h00FF, 16'h0F00,
                              16'h1234, 16'h0000, 16'h7FFF, 16'h0005};
  logic [N-1:0] t_src [8] = '{16'h0, 16'h0, 16'h0, 16'h00F0, 16'h0, 16'h0, 16'h0001, 16'h0005};
  logic [N-1:0] t_out [8] = '{16'h0001, 16'hFFFF, 16'hFF00, 16'h0FF0,
                              16'h0FF0, 16'h0FF0, 16'h8000, 16'h0000};
  logic         t_c   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int cyc, low, pulses;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; op = 4'd0; in_src = '0; in_dst = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out", out, 0);
    chk("rst_flags", {carryFlag, zeroFlag, negFlag}, 0);
    chk("rst_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);

    issue(4'd1, 16'hFFFF, 16'h0001);
    chk("add_valid", out_valid, 1);
    chk("add_out", out, 16'h0000);
    chk("add_czn", {carryFlag, zeroFlag, negFlag}, 3'b110);

    issue(4'd2, 16'h0003, 16'h0005);
    chk("sub_out", out, 16'hFFFE);
    chk("sub_czn", {carryFlag, zeroFlag, negFlag}, 3'b101);
    issue(4'd3, 16'h00F0, 16'h0F0F);
    chk("and_out", out, 16'h0000);
    chk("and_carry_kept", carryFlag, 1);

    for (int i = 0; i < 8; i++) begin
      issue(t_op[i], t_dst[i], t_src[i]);
      chk("tbl_valid", out_valid, 1);
      chk("tbl_out", out, t_out[i]);
      chk("tbl_carry", carryFlag, t_c[i]);
    end

    // flush with in_valid drops the op; flush after acceptance does not cancel the pulse
    @(negedge clk);
    op = 4'd1; in_dst = 16'h0001; in_src = 16'h0001; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_drop_valid", out_valid, 0);
    chk("flush_drop_out", out, 16'h0000);
    issue(4'd6, 16'h0010, 16'h0000);
    flush = 1'b1;
    chk("flush_pending_valid", out_valid, 1);
    chk("flush_pending_out", out, 16'h0011);
    @(negedge clk);
    flush = 1'b0;

    issue(4'd12, 16'h0100, 16'h0300);
    cyc = 1; low = 0;
    while (!out_valid && cyc < 40) begin
      if (!in_ready) low++;
      @(negedge clk);
      cyc++;
    end
    chk("mul_latency", cyc, 16);
    chk("mul_ready_low", low, 15);
    chk("mul_ready_back", in_ready, 1);
    chk("mul_hi", out_hi, 16'h0003);
    chk("mul_lo", out, 16'h0000);
    chk("mul_cz", {carryFlag, zeroFlag}, 2'b10);

    issue(4'd12, 16'h0005, 16'h0007);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("mflush_ready", in_ready, 1);
    chk("mflush_out", {out_hi, out}, 32'h0003_0000);
    chk("mflush_carry", carryFlag, 1);
    pulses = 0;
    repeat (20) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    chk("mflush_no_valid", pulses, 0);

    @(negedge clk);
    op = 4'd6; in_dst = 16'h8000; in_valid = 1'b1;
    @(negedge clk);
    op = 4'd8;
    chk("b2b_inc", out, 16'h8001);
    chk("b2b_inc_valid", out_valid, 1);
    @(negedge clk);
    op = 4'd10;
    chk("b2b_shl", out, 16'h0000);
    chk("b2b_shl_carry", carryFlag, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_setc_valid", out_valid, 1);
    chk("b2b_setc_out", out, 16'h0000);
    chk("b2b_cz", {carryFlag, zeroFlag}, 2'b11);

    issue(4'd1, 16'hFFFF, 16'h8001);
    chk("pre_rst_out", out, 16'h8000);
    issue(4'd12, 16'hFFFF, 16'hFFFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_out", {out_hi, out}, 0);
    chk("mrst_flags", {carryFlag, zeroFlag, negFlag}, 0);
    chk("mrst_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("mrst_no_valid", pulses, 0);
    chk("mrst_ready", in_ready, 1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
